// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte valid/ready handshake bundle between NUM_REQ requesters and the UART TX arbiter
//   req_valid [NUM_REQ]   : per-requester byte valid (requester -> arbiter)
//   req_data  [8*NUM_REQ] : byte i on bits [8i+7:8i] (requester -> arbiter)
//   req_ready [NUM_REQ]   : one-hot single-cycle accept pulse (arbiter -> requester)
//   modports: master = requester side, slave = arbiter side
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    modport master (output req_valid, output req_data, input req_ready);
    modport slave (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin shares one 8N1 UART TX line between NUM_REQ byte requesters
//   clk, rst_n  : system clock, asynchronous active-low reset
//   req         : uart_tx_arbiter_if.slave handshake (req_valid, req_data in; req_ready out)
//   grant_id_o  : requester whose frame is on the line (or was last sent)
//   busy_o      : high while a frame or inter-frame gap is in progress
//   tx_o        : serial output, idle high
//   UART_ARB_PARITY_EN: when defined, appends an even-parity bit (8E1 frames)
module uart_tx_arbiter #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CYC_COUNT    = SYSTEM_CLOCK / BAUD_RATE,
    parameter int NUM_REQ      = 4,
    parameter int GAP_BITS     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    uart_tx_arbiter_if.slave           req,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       tx_o
);
    localparam int CW = $clog2(CYC_COUNT);
    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = GAP_BITS > 1 ? $clog2(GAP_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_ARB_PARITY_EN
        PARITY,
`endif
        STOP,
        GAP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    shift_q;
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] grant_q;
    logic          tx_q;
    logic          busy_q;
    logic [IW-1:0] sel_d;
    logic [7:0]    byte_d;
    logic          bit_end;
`ifdef UART_ARB_PARITY_EN
    logic          par_q;
`endif

    // Two descending passes: the first finds the lowest valid index overall (wrap-around
    // fallback), the second overrides it with the lowest valid index above the pointer.
    always_comb begin
        sel_d  = ptr_q;
        byte_d = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req.req_valid[k]) sel_d = IW'(k);
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req.req_valid[k] && IW'(k) > ptr_q) sel_d = IW'(k);
        for (int k = 0; k < NUM_REQ; k++)
            if (sel_d == IW'(k)) byte_d = req.req_data[8*k +: 8];
    end

    assign bit_end       = cnt_q == CW'(CYC_COUNT - 1);
    // Ready is gated by rst_n so no accept can be signalled while reset is held.
    assign req.req_ready = (state_q == IDLE && |req.req_valid && rst_n) ? NUM_REQ'(1) << sel_d : '0;
    assign grant_id_o    = grant_q;
    assign busy_o        = busy_q;
    assign tx_o          = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            cnt_q <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (|req.req_valid) begin
                    shift_q <= byte_d;
`ifdef UART_ARB_PARITY_EN
                    par_q   <= ^byte_d;
`endif
                    grant_q <= sel_d;
                    ptr_q   <= sel_d;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= START;
                end
                START: if (bit_end) begin
                    bit_q   <= '0;
                    tx_q    <= shift_q[0];
                    state_q <= DATA;
                end
                // The shift register moves one place per bit, so the next bit is always shift_q[1].
                DATA: if (bit_end) begin
                    shift_q <= shift_q >> 1;
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
                        tx_q    <= par_q;
                        state_q <= PARITY;
`else
                        tx_q    <= 1'b1;
                        state_q <= STOP;
`endif
                    end else begin
                        tx_q <= shift_q[1];
                    end
                end
`ifdef UART_ARB_PARITY_EN
                PARITY: if (bit_end) begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
`endif
                STOP: if (bit_end) begin
                    gap_q   <= '0;
                    busy_q  <= GAP_BITS != 0;
                    state_q <= GAP_BITS == 0 ? IDLE : GAP;
                end
                GAP: if (bit_end) begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GW'(GAP_BITS - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized self-checking bench with a frame-level reference model for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int CYC = 16;
    localparam int NR  = 4;
`ifdef UART_ARB_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b, tx_a, tx_b;
    logic [3:0] vm[2];
    logic [31:0] dm[2];
    int         ptr_m[2];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) ifa ();
    uart_tx_arbiter_if #(.NUM_REQ(NR)) ifb ();

    uart_tx_arbiter #(.SYSTEM_CLOCK(160), .BAUD_RATE(10), .NUM_REQ(NR), .GAP_BITS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(ifa), .grant_id_o(gid_a), .busy_o(busy_a), .tx_o(tx_a)
    );
    uart_tx_arbiter #(.SYSTEM_CLOCK(160), .BAUD_RATE(10), .NUM_REQ(NR), .GAP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(ifb), .grant_id_o(gid_b), .busy_o(busy_b), .tx_o(tx_b)
    );

    function automatic logic txo(input int g);
        return g != 0 ? tx_b : tx_a;
    endfunction
    function automatic logic bsy(input int g);
        return g != 0 ? busy_b : busy_a;
    endfunction
    function automatic logic [1:0] gid(input int g);
        return g != 0 ? gid_b : gid_a;
    endfunction
    function automatic logic [3:0] rdy(input int g);
        return g != 0 ? ifb.req_ready : ifa.req_ready;
    endfunction

    task automatic drive(input int g);
        if (g == 0) begin
            ifa.req_valid = vm[0];
            ifa.req_data  = dm[0];
        end else begin
            ifb.req_valid = vm[1];
            ifb.req_data  = dm[1];
        end
    endtask

    // Called in an IDLE cycle (#1 after negedge) with at least one valid requester.
    // Picks the expected winner by round-robin rule, then checks the whole frame bit by bit.
    task automatic serve(input int g, input bit reload, input bit add);
        int sel;
        int len;
        int k;
        logic [7:0] b;
        logic exp_tx;
        sel = -1;
        for (int j = 1; j <= NR; j++) begin
            if (sel < 0 && vm[g][(ptr_m[g] + j) % NR]) sel = (ptr_m[g] + j) % NR;
        end
        if (sel < 0) return;
        b = dm[g][8*sel +: 8];
        len = (FB + (g != 0 ? 2 : 0)) * CYC;
        n_chk++;
        if (rdy(g) !== 4'(1 << sel)) begin
            n_fail++;
            $display("FAIL ready_accept dut%0d: got %b expected %b", g, rdy(g), 4'(1 << sel));
        end
        n_chk++;
        if (bsy(g) !== 1'b0 || txo(g) !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_before_frame dut%0d: got busy=%b tx=%b expected busy=0 tx=1", g, bsy(g), txo(g));
        end
        ptr_m[g] = sel;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if (reload) dm[g][8*sel +: 8] = 8'($urandom);
                else vm[g][sel] = 1'b0;
                drive(g);
            end
            if (add && c == len / 2) begin
                int r;
                r = $urandom_range(0, NR - 1);
                if (!vm[g][r]) begin
                    vm[g][r] = 1'b1;
                    dm[g][8*r +: 8] = 8'($urandom);
                end
                drive(g);
            end
            #1;
            k = c / CYC;
            if (k == 0) exp_tx = 1'b0;
            else if (k <= 8) exp_tx = b[k-1];
            else if (FB == 11 && k == 9) exp_tx = ^b;
            else exp_tx = 1'b1;
            n_chk++;
            if (txo(g) !== exp_tx) begin
                n_fail++;
                $display("FAIL tx_bit dut%0d byte=%h offset=%0d: got %b expected %b", g, b, c, txo(g), exp_tx);
            end
            n_chk++;
            if (bsy(g) !== 1'b1 || rdy(g) !== 4'b0 || gid(g) !== 2'(sel)) begin
                n_fail++;
                $display("FAIL frame_status dut%0d offset=%0d: got busy=%b ready=%b grant=%0d expected busy=1 ready=0000 grant=%0d",
                         g, c, bsy(g), rdy(g), gid(g), sel);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        vm[0] = 4'b0; vm[1] = 4'b0; dm[0] = '0; dm[1] = '0;
        drive(0); drive(1);
        repeat (2) @(negedge clk);
        vm[0] = 4'b1111;
        drive(0);
        #1;
        n_chk++;
        if (rdy(0) !== 4'b0) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %b expected 0000", rdy(0));
        end
        vm[0] = 4'b0;
        drive(0);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m[0] = NR - 1; ptr_m[1] = NR - 1;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_chk++;
            if (txo(g) !== 1'b1 || bsy(g) !== 1'b0 || rdy(g) !== 4'b0 || gid(g) !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got tx=%b busy=%b ready=%b grant=%0d expected tx=1 busy=0 ready=0000 grant=0",
                         g, txo(g), bsy(g), rdy(g), gid(g));
            end
        end
    endtask

    task automatic test_single();
        vm[0] = 4'b0001;
        dm[0][7:0] = 8'h55;
        drive(0);
        #1;
        serve(0, 1'b0, 1'b0);
        n_chk++;
        if (txo(0) !== 1'b1 || bsy(0) !== 1'b0 || rdy(0) !== 4'b0) begin
            n_fail++;
            $display("FAIL single_idle_after: got tx=%b busy=%b ready=%b expected tx=1 busy=0 ready=0000", txo(0), bsy(0), rdy(0));
        end
    endtask

    task automatic test_pair();
        vm[0] = 4'b0101;
        dm[0][7:0] = 8'hA0;
        dm[0][23:16] = 8'h0B;
        drive(0);
        #1;
        serve(0, 1'b0, 1'b0);
        serve(0, 1'b0, 1'b0);
    endtask

    task automatic test_all_requesters();
        vm[0] = 4'b1111;
        dm[0] = $urandom;
        drive(0);
        #1;
        repeat (6) serve(0, 1'b1, 1'b0);
        vm[0] = 4'b0;
        drive(0);
        #1;
        n_chk++;
        if (rdy(0) !== 4'b0 || bsy(0) !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop_idle: got ready=%b busy=%b expected ready=0000 busy=0", rdy(0), bsy(0));
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_parity_frame();
        vm[0] = 4'b0010;
        dm[0][15:8] = 8'h07;
        drive(0);
        #1;
        serve(0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            if (vm[0] == 4'b0) begin
                vm[0] = 4'($urandom_range(1, 15));
                dm[0] = $urandom;
                drive(0);
                #1;
            end
            serve(0, 1'($urandom_range(0, 1)), 1'b1);
        end
        for (int it = 0; it < NR; it++) begin
            if (vm[0] != 4'b0) serve(0, 1'b0, 1'b0);
        end
        n_chk++;
        if (rdy(0) !== 4'b0 || bsy(0) !== 1'b0 || txo(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL random_drain_idle: got ready=%b busy=%b tx=%b expected 0000/0/1", rdy(0), bsy(0), txo(0));
        end
    endtask

    task automatic test_gap();
        vm[1] = 4'b0011;
        dm[1] = $urandom;
        drive(1);
        #1;
        serve(1, 1'b0, 1'b0);
        serve(1, 1'b0, 1'b0);
        n_chk++;
        if (txo(1) !== 1'b1 || bsy(1) !== 1'b0 || rdy(1) !== 4'b0) begin
            n_fail++;
            $display("FAIL gap_idle_after: got tx=%b busy=%b ready=%b expected 1/0/0000", txo(1), bsy(1), rdy(1));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom) & 8'hF7;
        vm[0] = 4'b0100;
        dm[0][23:16] = b;
        drive(0);
        #1;
        n_chk++;
        if (rdy(0) !== 4'b0100) begin
            n_fail++;
            $display("FAIL midreset_accept: got %b expected 0100", rdy(0));
        end
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 0) begin
                vm[0] = 4'b0;
                drive(0);
            end
        end
        #1;
        n_chk++;
        if (txo(0) !== 1'b0 || gid(0) !== 2'd2) begin
            n_fail++;
            $display("FAIL midreset_data_bit3: got tx=%b grant=%0d expected tx=0 grant=2", txo(0), gid(0));
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (txo(0) !== 1'b1 || bsy(0) !== 1'b0 || gid(0) !== 2'd0 || rdy(0) !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got tx=%b busy=%b grant=%0d ready=%b expected 1/0/0/0000", txo(0), bsy(0), gid(0), rdy(0));
        end
        vm[0] = 4'b1001;
        dm[0] = $urandom;
        drive(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ptr_m[0] = NR - 1; ptr_m[1] = NR - 1;
        #1;
        serve(0, 1'b0, 1'b0);
        n_chk++;
        if (rdy(0) !== 4'b1000) begin
            n_fail++;
            $display("FAIL midreset_second_grant: got %b expected 1000", rdy(0));
        end
        serve(0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_all_requesters();
        test_parity_frame();
        test_random();
        test_gap();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
